spi_mem_burst: RTL and testbench
================================

SPI_MEM_BURST -- requirements
Module: spi_mem_burst

Interface
REQ-001 Parameter DATA_W, default 8, width of each memory word in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  opens a burst; loads the address pointer from addr_in.
REQ-006 stop  input  1  closes the current burst.
REQ-007 addr_in  input  ADDR_W  burst start address, sampled only when start=1.
REQ-008 write  input  1  write beat at the current pointer.
REQ-009 read  input  1  read beat at the current pointer.
REQ-010 wp  input  1  write-protect; while wp=1, writes are blocked.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  read data, registered.
REQ-013 rd_valid  output  1  one-cycle pulse, data_out valid.
REQ-014 busy  output  1  high while a burst is open (state ACTIVE).
REQ-015 beat_cnt  output  ADDR_W+1  beats completed in the current burst.
REQ-016 err  output  1  one-cycle pulse, illegal access.
REQ-017 par_err  output  1  one-cycle pulse, parity mismatch on read; tied 0 without SPI_MEM_PARITY_EN.

Function
REQ-018 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-019 IDLE->ACTIVE on start=1. ACTIVE->IDLE on stop=1 without start. start in ACTIVE SHALL restart the burst (reload pointer, clear beat_cnt).
REQ-020 A beat is any cycle in ACTIVE, or with start=1, in which read=1 or write=1.
REQ-021 Beat address SHALL be addr_in when start=1, else the pointer; after a beat, pointer = beat address + 1, wrapping DEPTH-1 -> 0.
REQ-022 A write beat with wp=0 SHALL store data_in; with wp=1 memory SHALL be unchanged, err SHALL pulse, and the pointer SHALL still advance.
REQ-023 A read beat SHALL drive data_out = mem[beat address] and rd_valid=1 on the following cycle (latency 1); otherwise rd_valid=0 and data_out holds its last value.
REQ-024 read and write in the same beat SHALL return the pre-write (old) data and advance the pointer once.
REQ-025 read or write in IDLE without start SHALL be ignored (no memory or pointer change, rd_valid=0) and err SHALL pulse.
REQ-026 stop and a beat in the same cycle: the beat SHALL complete, then the FSM enters IDLE.
REQ-027 beat_cnt SHALL increment per beat, saturate at 2**ADDR_W, and hold its value in IDLE until the next start.
REQ-028 busy SHALL equal (state == ACTIVE), registered.

Reset
REQ-029 While rst=1, all memory words SHALL be 0, the pointer 0, state IDLE, and data_out, rd_valid, busy, beat_cnt, err, par_err all 0.
REQ-030 rst asserted mid-burst SHALL abort the burst immediately with no pending rd_valid afterwards.

Configuration
REQ-031 With SPI_MEM_PARITY_EN defined, each word SHALL store one extra even-parity bit computed from data_in on write; on read, a mismatch SHALL pulse par_err together with rd_valid.
REQ-032 Without SPI_MEM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be constant 0.

Verification
REQ-033 Reset, then start addr_in=3 with write=1; data_in 0xA1, 0xB2, 0xC3 in consecutive cycles; stop -> mem[3..5] = A1, B2, C3, beat_cnt=3, busy=0.
REQ-034 start addr_in=14, four read beats -> data_out in order mem[14], mem[15], mem[0], mem[1], each with rd_valid one cycle after its beat (wrap check).
REQ-035 mem[7]=0x55; one beat with read=1, write=1, data_in=0xAA at pointer 7 -> data_out=0x55, then a later read of 7 returns 0xAA.
REQ-036 wp=1, write beat 0xFF at address 2 -> mem[2] unchanged, err pulses 1 cycle, pointer=3; read=1 while IDLE -> err pulse, rd_valid stays 0.
REQ-037 rst pulsed mid-burst after 2 of 4 beats -> busy=0, beat_cnt=0, all words read back as 0.
REQ-038 With SPI_MEM_PARITY_EN defined, force a parity bit flip on stored word 5, then read 5 -> par_err=1 coincident with rd_valid; without the macro, par_err stays 0.

Source files
------------

// File: rtl/spi_mem_burst_if.sv
// Bus bundle for spi_mem_burst: burst control, beat strobes and read/status returns.
// master drives the burst requests; slave is the memory side.
interface spi_mem_burst_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] addr_in;
    logic              write;
    logic              read;
    logic              wp;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic [ADDR_W:0]   beat_cnt;
    logic              err;
    logic              par_err;

    modport master (
        output start, stop, addr_in, write, read, wp, data_in,
        input  data_out, rd_valid, busy, beat_cnt, err, par_err
    );

    modport slave (
        input  start, stop, addr_in, write, read, wp, data_in,
        output data_out, rd_valid, busy, beat_cnt, err, par_err
    );
endinterface

// File: rtl/spi_mem_burst.sv
// Burst-addressed register memory with an auto-incrementing, wrapping pointer.
// Define SPI_MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module spi_mem_burst #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            rst,
    spi_mem_burst_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef SPI_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                       state_q, state_d;
    logic [DEPTH-1:0][MEM_W-1:0]  mem_q, mem_d;
    logic [ADDR_W-1:0]            ptr_q, ptr_d;
    logic [DATA_W-1:0]            data_out_q, data_out_d;
    logic [ADDR_W:0]              beat_cnt_q, beat_cnt_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         busy_q, busy_d;
    logic                         err_q, err_d;

    logic                         access, beat;
    logic [ADDR_W-1:0]            beat_addr;
    logic [MEM_W-1:0]             rd_word;

    always_comb begin
        access    = bus.read | bus.write;
        beat      = access & (bus.start | (state_q == ACTIVE));
        beat_addr = bus.start ? bus.addr_in : ptr_q;
        rd_word   = mem_q[beat_addr];

        state_d = state_q;
        if (bus.start)
            state_d = ACTIVE;
        else if (state_q == ACTIVE && bus.stop)
            state_d = IDLE;
        busy_d = (state_d == ACTIVE);

        ptr_d = ptr_q;
        if (beat)
            ptr_d = beat_addr + ADDR_W'(1);
        else if (bus.start)
            ptr_d = bus.addr_in;

        // A start cycle may itself be the first beat of the new burst.
        beat_cnt_d = beat_cnt_q;
        if (bus.start)
            beat_cnt_d = (ADDR_W+1)'(beat);
        else if (beat && beat_cnt_q != (ADDR_W+1)'(DEPTH))
            beat_cnt_d = beat_cnt_q + (ADDR_W+1)'(1);

        rd_valid_d = beat & bus.read;
        data_out_d = rd_valid_d ? rd_word[DATA_W-1:0] : data_out_q;

        // Idle access without start, or a protected write beat.
        err_d = (access & ~beat) | (beat & bus.write & bus.wp);

        mem_d = mem_q;
        if (beat && bus.write && !bus.wp)
`ifdef SPI_MEM_PARITY_EN
            mem_d[beat_addr] = {^bus.data_in, bus.data_in};
`else
            mem_d[beat_addr] = bus.data_in;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_q      <= '0;
            ptr_q      <= '0;
            data_out_q <= '0;
            beat_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            beat_cnt_q <= beat_cnt_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

`ifdef SPI_MEM_PARITY_EN
    logic par_err_q, par_err_d;

    // Stored word includes its parity bit, so a clean word XORs to zero.
    always_comb par_err_d = rd_valid_d & (^rd_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end
    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.beat_cnt = beat_cnt_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_mem_burst.sv
// Directed bench for spi_mem_burst: burst write/read, wrap, read-modify beat,
// write protect, idle access, beat counter saturation, stop-with-beat, mid-burst reset.
module tb_spi_mem_burst;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [DW-1:0] exp_mem [DEPTH];

    spi_mem_burst_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    spi_mem_burst #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.addr_in = '0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.wp      = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic close_burst();
        idle_in();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic burst_write(input int a, input int n, input logic [DW-1:0] base,
                               input logic [DW-1:0] inc);
        for (int i = 0; i < n; i++) begin
            bus.start   = (i == 0);
            bus.addr_in = AW'(a);
            bus.write   = 1'b1;
            bus.data_in = base + DW'(i) * inc;
            step();
            exp_mem[(a + i) % DEPTH] = base + DW'(i) * inc;
        end
        close_burst();
    endtask

    task automatic burst_read(input int a, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.start   = (i == 0);
            bus.addr_in = AW'(a);
            bus.read    = 1'b1;
            step();
            chk({tag, "_rv"}, {31'd0, bus.rd_valid}, 32'd1);
            chk({tag, "_do"}, {24'd0, bus.data_out}, {24'd0, exp_mem[(a + i) % DEPTH]});
            chk({tag, "_pe"}, {31'd0, bus.par_err}, 32'd0);
        end
        close_burst();
        chk({tag, "_rv_end"}, {31'd0, bus.rd_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        idle_in();
        step();
        step();
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_beat_cnt", {27'd0, bus.beat_cnt}, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        chk("rst_err",      {31'd0, bus.err},      32'd0);
        chk("rst_par_err",  {31'd0, bus.par_err},  32'd0);
        rst = 1'b0;
        step();

        // A1, B2, C3 at 3..5
        burst_write(3, 3, 8'hA1, 8'h11);
        chk("wr3_beat_cnt", {27'd0, bus.beat_cnt}, 32'd3);
        chk("wr3_busy",     {31'd0, bus.busy},     32'd0);
        burst_read(3, 3, "wr3");

        // wrap 14,15,0,1
        burst_write(14, 4, 8'h1E, 8'h01);
        burst_read(14, 4, "wrap");

        // simultaneous read+write returns old data, pointer advances once
        burst_write(7, 2, 8'h55, 8'h10);
        bus.start = 1'b1; bus.addr_in = 4'd7; bus.read = 1'b1; bus.write = 1'b1; bus.data_in = 8'hAA;
        step();
        chk("rw_old_rv", {31'd0, bus.rd_valid}, 32'd1);
        chk("rw_old_do", {24'd0, bus.data_out}, 32'h55);
        exp_mem[7] = 8'hAA;
        bus.start = 1'b0; bus.write = 1'b0;
        step();
        chk("rw_next_do", {24'd0, bus.data_out}, {24'd0, exp_mem[8]});
        close_burst();
        burst_read(7, 1, "rw_new");

        // write protect: memory unchanged, err pulse, pointer still advances
        bus.start = 1'b1; bus.addr_in = 4'd2; bus.write = 1'b1; bus.wp = 1'b1; bus.data_in = 8'hFF;
        step();
        chk("wp_err",  {31'd0, bus.err},  32'd1);
        chk("wp_busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0; bus.write = 1'b0; bus.wp = 1'b0; bus.read = 1'b1;
        step();
        chk("wp_err_pulse", {31'd0, bus.err},      32'd0);
        chk("wp_ptr_rv",    {31'd0, bus.rd_valid}, 32'd1);
        chk("wp_ptr_do",    {24'd0, bus.data_out}, {24'd0, exp_mem[3]});
        close_burst();
        burst_read(2, 1, "wp_mem");

        // idle read without start
        bus.read = 1'b1;
        step();
        chk("idle_err", {31'd0, bus.err},      32'd1);
        chk("idle_rv",  {31'd0, bus.rd_valid}, 32'd0);
        chk("idle_do",  {24'd0, bus.data_out}, {24'd0, exp_mem[2]});
        bus.read = 1'b0;
        step();
        chk("idle_err_pulse", {31'd0, bus.err}, 32'd0);

        // stop in the same cycle as the last beat
        bus.start = 1'b1; bus.addr_in = 4'd9; bus.write = 1'b1; bus.data_in = 8'h99;
        step();
        bus.start = 1'b0; bus.stop = 1'b1; bus.data_in = 8'h9A;
        step();
        exp_mem[9] = 8'h99; exp_mem[10] = 8'h9A;
        chk("stopbeat_busy", {31'd0, bus.busy},     32'd0);
        chk("stopbeat_cnt",  {27'd0, bus.beat_cnt}, 32'd2);
        idle_in();
        burst_read(9, 2, "stopbeat");

        // beat counter saturation at DEPTH
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.start = (i == 0); bus.addr_in = 4'd0; bus.read = 1'b1;
            step();
            if (i == DEPTH - 2) chk("sat_15", {27'd0, bus.beat_cnt}, 32'd15);
        end
        chk("sat_cnt", {27'd0, bus.beat_cnt}, 32'd16);
        close_burst();
        step();
        chk("sat_hold_idle", {27'd0, bus.beat_cnt}, 32'd16);

`ifdef SPI_MEM_PARITY_EN
        burst_write(5, 1, 8'h3C, 8'h00);
        dut.mem_q[5][DW] = ~dut.mem_q[5][DW];
        bus.start = 1'b1; bus.addr_in = 4'd5; bus.read = 1'b1;
        step();
        chk("par_rv", {31'd0, bus.rd_valid}, 32'd1);
        chk("par_pe", {31'd0, bus.par_err},  32'd1);
        chk("par_do", {24'd0, bus.data_out}, 32'h3C);
        close_burst();
        chk("par_pe_pulse", {31'd0, bus.par_err}, 32'd0);
`else
        burst_write(5, 1, 8'h3C, 8'h00);
        burst_read(5, 1, "par");
`endif

        // reset mid-burst after two of four beats
        bus.start = 1'b1; bus.addr_in = 4'd0; bus.write = 1'b1; bus.data_in = 8'h77;
        step();
        bus.start = 1'b0; bus.data_in = 8'h78;
        step();
        chk("mid_cnt_pre", {27'd0, bus.beat_cnt}, 32'd2);
        bus.write = 1'b0; bus.read = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, bus.busy},     32'd0);
        chk("mid_cnt",  {27'd0, bus.beat_cnt}, 32'd0);
        chk("mid_rv",   {31'd0, bus.rd_valid}, 32'd0);
        chk("mid_do",   {24'd0, bus.data_out}, 32'd0);
        step();
        chk("mid_rv_after", {31'd0, bus.rd_valid}, 32'd0);
        idle_in();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        step();
        burst_read(0, DEPTH, "mid_mem");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
